// File: rtl/muldiv_pkg.sv
// Shared constants and helpers for the multiply/divide sequencing controller.
// The op-bit indices match the one-hot req_op layout presented by EX.
package muldiv_pkg;

   localparam int OP_MULT  = 0;
   localparam int OP_MULTU = 1;
   localparam int OP_DIV   = 2;
   localparam int OP_DIVU  = 3;
   localparam int OP_MFHI  = 4;
   localparam int OP_MFLO  = 5;
   localparam int OP_MTHI  = 6;
   localparam int OP_MTLO  = 7;

   typedef logic [1:0] state_t;
   localparam state_t ST_IDLE = 2'd0;
   localparam state_t ST_MUL  = 2'd1;
   localparam state_t ST_DIV  = 2'd2;
   localparam state_t ST_FIN  = 2'd3;

   localparam logic [31:0] DIV_BY_ZERO_Q = 32'hFFFF_FFFF;

   typedef enum logic [2:0] {
      SEL_NONE, SEL_DIV, SEL_DIVU, SEL_MULT, SEL_MULTU, SEL_MTHI, SEL_MTLO
   } op_sel_e;

   // mfhi/mflo have no side effects, so they decode to SEL_NONE.
   function automatic op_sel_e decode_op(input logic [7:0] op);
      if (op[OP_DIV])   return SEL_DIV;
      if (op[OP_DIVU])  return SEL_DIVU;
      if (op[OP_MULT])  return SEL_MULT;
      if (op[OP_MULTU]) return SEL_MULTU;
      if (op[OP_MTHI])  return SEL_MTHI;
      if (op[OP_MTLO])  return SEL_MTLO;
      return SEL_NONE;
   endfunction

   function automatic logic [31:0] abs32(input logic [31:0] v);
      return v[31] ? (~v + 32'd1) : v;
   endfunction

endpackage

// File: rtl/muldiv_ctrl_if.sv
// EX-stage request/response bundle for the multiply/divide controller.
// valid/ready: an operation is accepted on a rising edge where req_valid and req_ready are both high.
interface muldiv_ctrl_if;
   import muldiv_pkg::*;

   logic        req_valid;
   logic [7:0]  req_op;
   logic [31:0] src1;
   logic [31:0] src2;
   logic        req_ready;
   logic        ex_stop;
   logic        flush;
   logic [31:0] rd_data;
   logic        busy;
   logic        done;
   logic [31:0] hi;
   logic [31:0] lo;
   state_t      dbg_state;

   modport master (
      output req_valid, req_op, src1, src2, ex_stop, flush,
      input  req_ready, rd_data, busy, done, hi, lo, dbg_state
   );

   modport slave (
      input  req_valid, req_op, src1, src2, ex_stop, flush,
      output req_ready, rd_data, busy, done, hi, lo, dbg_state
   );
endinterface

// File: rtl/muldiv_ctrl_div_iter.sv
// Unsigned restoring divider, one quotient bit per cycle for ITER cycles.
// Sign handling and divide-by-zero results are applied by the controller.
module div_iter #(
   parameter int W    = 32,
   parameter int ITER = 32
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         start,
   input  logic         abort,
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   output logic         busy,
   output logic [W-1:0] q,
   output logic [W-1:0] r
);
   localparam int CW = $clog2(ITER + 1);

   logic [CW-1:0] cnt_q;
   logic [W-1:0]  q_q;
   logic [W-1:0]  r_q;
   logic [W-1:0]  b_q;
   logic [W:0]    rem_sh;
   logic [W:0]    diff;

   // Partial remainder never exceeds 2*b-1, so diff[W] is a clean borrow flag.
   assign rem_sh = {r_q, q_q[W-1]};
   assign diff   = rem_sh - {1'b0, b_q};

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q <= '0;
         q_q   <= '0;
         r_q   <= '0;
         b_q   <= '0;
      end else if (abort) begin
         cnt_q <= '0;
      end else if (start) begin
         cnt_q <= CW'(ITER);
         q_q   <= a;
         r_q   <= '0;
         b_q   <= b;
      end else if (cnt_q != '0) begin
         cnt_q <= cnt_q - CW'(1);
         if (!diff[W]) begin
            r_q <= diff[W-1:0];
            q_q <= {q_q[W-2:0], 1'b1};
         end else begin
            r_q <= rem_sh[W-1:0];
            q_q <= {q_q[W-2:0], 1'b0};
         end
      end
   end

   assign busy = (cnt_q != '0);
   assign q    = q_q;
   assign r    = r_q;
endmodule

// File: rtl/muldiv_ctrl.sv
// Multiply/divide sequencer owning HI/LO: fixed-latency multiplier pipeline,
// iterative divider, flush abort and exception-shadow write suppression.
module muldiv_ctrl
   import muldiv_pkg::*;
#(
   parameter int MUL_LAT  = 2,
   parameter int DIV_ITER = 32
) (
   input  logic        clk,
   input  logic        reset,
   muldiv_ctrl_if.slave bus
);
   localparam int CNT_MAX = (MUL_LAT > DIV_ITER) ? MUL_LAT : DIV_ITER;
   localparam int CNT_W   = $clog2(CNT_MAX + 1);

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             kill_q, kill_d;
   logic [31:0]      hi_q, hi_d;
   logic [31:0]      lo_q, lo_d;
   logic             is_div_q, qneg_q, rneg_q, dbz_q;
   logic [31:0]      dsrc1_q;
   logic [63:0]      pipe_q [MUL_LAT];

   op_sel_e     sel;
   logic        accept;
   logic        mul_start;
   logic        div_start;
   logic        div_signed;
   logic [63:0] mul_a;
   logic [63:0] mul_b;
   logic [63:0] mul_prod;
   logic        div_busy;
   logic [31:0] div_q;
   logic [31:0] div_r;
   logic [31:0] div_a;
   logic [31:0] div_b;
   logic [31:0] res_hi;
   logic [31:0] res_lo;

   assign sel        = decode_op(bus.req_op);
   assign accept     = bus.req_valid && (state_q == ST_IDLE) && !bus.flush && (sel != SEL_NONE);
   assign mul_start  = accept && ((sel == SEL_MULT) || (sel == SEL_MULTU));
   assign div_start  = accept && ((sel == SEL_DIV) || (sel == SEL_DIVU));
   assign div_signed = (sel == SEL_DIV);

   // Extending to 64 bits is equivalent to the 33-bit signed multiply for the low 64 product bits.
   assign mul_a    = (sel == SEL_MULT) ? {{32{bus.src1[31]}}, bus.src1} : {32'd0, bus.src1};
   assign mul_b    = (sel == SEL_MULT) ? {{32{bus.src2[31]}}, bus.src2} : {32'd0, bus.src2};
   assign mul_prod = mul_a * mul_b;

   assign div_a = div_signed ? abs32(bus.src1) : bus.src1;
   assign div_b = div_signed ? abs32(bus.src2) : bus.src2;

   div_iter #(.W(32), .ITER(DIV_ITER)) u_div (
      .clk   (clk),
      .rst   (reset),
      .start (div_start),
      .abort (bus.flush),
      .a     (div_a),
      .b     (div_b),
      .busy  (div_busy),
      .q     (div_q),
      .r     (div_r)
   );

   always_comb begin
      res_lo = qneg_q ? (~div_q + 32'd1) : div_q;
      res_hi = rneg_q ? (~div_r + 32'd1) : div_r;
      if (dbz_q) begin
         res_lo = DIV_BY_ZERO_Q;
         res_hi = dsrc1_q;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      kill_d  = kill_q;
      case (state_q)
         ST_IDLE: begin
            if (mul_start) begin
               state_d = ST_MUL;
               cnt_d   = CNT_W'(MUL_LAT - 1);
               kill_d  = bus.ex_stop;
            end else if (div_start) begin
               state_d = ST_DIV;
               cnt_d   = CNT_W'(DIV_ITER - 1);
               kill_d  = bus.ex_stop;
            end
         end
         ST_MUL: begin
            if (cnt_q == '0) state_d = ST_FIN;
            else             cnt_d   = cnt_q - CNT_W'(1);
         end
         ST_DIV: begin
            if ((cnt_q == '0) || !div_busy) state_d = ST_FIN;
            else                            cnt_d   = cnt_q - CNT_W'(1);
         end
         ST_FIN:  state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
      if (bus.flush) begin
         state_d = ST_IDLE;
         cnt_d   = '0;
         kill_d  = 1'b0;
      end
   end

   // A flush or exception shadow in FIN still blocks the write even though done is visible.
   always_comb begin
      hi_d = hi_q;
      lo_d = lo_q;
      if (accept && (sel == SEL_MTHI) && !bus.ex_stop) hi_d = bus.src1;
      if (accept && (sel == SEL_MTLO) && !bus.ex_stop) lo_d = bus.src1;
      if ((state_q == ST_FIN) && !kill_q && !bus.ex_stop && !bus.flush) begin
         if (is_div_q) begin
            hi_d = res_hi;
            lo_d = res_lo;
         end else begin
            hi_d = pipe_q[MUL_LAT-1][63:32];
            lo_d = pipe_q[MUL_LAT-1][31:0];
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         kill_q  <= 1'b0;
         hi_q    <= '0;
         lo_q    <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         kill_q  <= kill_d;
         hi_q    <= hi_d;
         lo_q    <= lo_d;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         is_div_q <= 1'b0;
         qneg_q   <= 1'b0;
         rneg_q   <= 1'b0;
         dbz_q    <= 1'b0;
         dsrc1_q  <= '0;
      end else if (div_start) begin
         is_div_q <= 1'b1;
         qneg_q   <= div_signed && (bus.src1[31] ^ bus.src2[31]);
         rneg_q   <= div_signed && bus.src1[31];
         dbz_q    <= (bus.src2 == 32'd0);
         dsrc1_q  <= bus.src1;
      end else if (mul_start) begin
         is_div_q <= 1'b0;
      end
   end

   // Stage 0 holds its product until the next multiply so the last stage stays valid in FIN.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < MUL_LAT; i++) pipe_q[i] <= '0;
      end else begin
         if (mul_start) pipe_q[0] <= mul_prod;
         for (int i = 1; i < MUL_LAT; i++) pipe_q[i] <= pipe_q[i-1];
      end
   end

   assign bus.req_ready = (state_q == ST_IDLE);
   assign bus.busy      = (state_q != ST_IDLE);
   assign bus.done      = (state_q == ST_FIN);
   assign bus.hi        = hi_q;
   assign bus.lo        = lo_q;
   assign bus.dbg_state = state_q;
   assign bus.rd_data   = bus.req_op[OP_MFHI] ? hi_q :
                          bus.req_op[OP_MFLO] ? lo_q : 32'd0;
endmodule

// File: tb/tb_muldiv_ctrl.sv
// Directed bench for muldiv_ctrl: multiply/divide results, latency, flush,
// exception shadow and asynchronous reset behaviour.
module tb_muldiv_ctrl;
   import muldiv_pkg::*;

   localparam int MUL_LAT  = 2;
   localparam int DIV_ITER = 32;

   logic clk = 1'b0;
   logic reset;

   muldiv_ctrl_if ifc();

   muldiv_ctrl #(.MUL_LAT(MUL_LAT), .DIV_ITER(DIV_ITER)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (ifc)
   );

   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;
   logic [31:0] exp_q[$];

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   task automatic drive_idle();
      ifc.req_valid = 1'b0;
      ifc.req_op    = 8'h00;
      ifc.src1      = 32'd0;
      ifc.src2      = 32'd0;
      ifc.ex_stop   = 1'b0;
      ifc.flush     = 1'b0;
   endtask

   // Presents one request for a single cycle; returns at the negedge after the accept edge.
   task automatic issue(input logic [7:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic stop, input logic fl);
      @(negedge clk);
      ifc.req_valid = 1'b1;
      ifc.req_op    = op;
      ifc.src1      = a;
      ifc.src2      = b;
      ifc.ex_stop   = stop;
      ifc.flush     = fl;
      @(negedge clk);
      drive_idle();
   endtask

   task automatic wait_done(output int cyc, output bit stall_ok);
      cyc      = 0;
      stall_ok = 1'b1;
      for (int i = 1; i <= 100; i++) begin
         if (!(ifc.busy && !ifc.req_ready)) stall_ok = 1'b0;
         if (ifc.done) begin
            cyc = i;
            break;
         end
         @(negedge clk);
      end
   endtask

   task automatic run_op(input string tag, input logic [7:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic stop, input int exp_cyc,
                         input logic [31:0] exp_hi, input logic [31:0] exp_lo);
      int cyc;
      bit stall_ok;
      exp_q.push_back(exp_hi);
      exp_q.push_back(exp_lo);
      issue(op, a, b, stop, 1'b0);
      wait_done(cyc, stall_ok);
      chk({tag, "_done_cyc"}, 32'(cyc), 32'(exp_cyc));
      chk({tag, "_stall"}, {31'd0, stall_ok}, 32'd1);
      @(negedge clk);
      chk({tag, "_hi"}, ifc.hi, exp_q.pop_front());
      chk({tag, "_lo"}, ifc.lo, exp_q.pop_front());
   endtask

   task automatic count_done(input int cycles, output int n);
      n = 0;
      for (int i = 0; i < cycles; i++) begin
         @(negedge clk);
         if (ifc.done) n++;
      end
   endtask

   initial begin
      int n_done;
      drive_idle();
      reset = 1'b1;
      repeat (2) @(negedge clk);
      chk("rst_busy",  {31'd0, ifc.busy},      32'd0);
      chk("rst_done",  {31'd0, ifc.done},      32'd0);
      chk("rst_ready", {31'd0, ifc.req_ready}, 32'd1);
      chk("rst_hi",    ifc.hi, 32'd0);
      chk("rst_lo",    ifc.lo, 32'd0);
      reset = 1'b0;

      // req_op == 0 is ignored
      issue(8'h00, 32'd5, 32'd6, 1'b0, 1'b0);
      chk("op0_busy",  {31'd0, ifc.busy},      32'd0);
      chk("op0_ready", {31'd0, ifc.req_ready}, 32'd1);

      run_op("mult",  8'h01, 32'hFFFF_FFFF, 32'd2, 1'b0, MUL_LAT + 1, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
      run_op("multu", 8'h02, 32'hFFFF_FFFF, 32'd2, 1'b0, MUL_LAT + 1, 32'h0000_0001, 32'hFFFF_FFFE);
      run_op("div",   8'h04, 32'hFFFF_FFF9, 32'd2, 1'b0, 33, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
      run_op("divu",  8'h08, 32'd100, 32'd7, 1'b0, 33, 32'd2, 32'd14);
      run_op("divu0", 8'h08, 32'd5, 32'd0, 1'b0, 33, 32'd5, 32'hFFFF_FFFF);
      run_op("div0",  8'h04, 32'h8000_0000, 32'd0, 1'b0, 33, 32'h8000_0000, 32'hFFFF_FFFF);
      // div beats mult when both bits are set: -20/6 -> q=-3, r=-2
      run_op("prio",  8'h05, 32'hFFFF_FFEC, 32'd6, 1'b0, 33, 32'hFFFF_FFFE, 32'hFFFF_FFFD);

      issue(8'h40, 32'h11, 32'd0, 1'b0, 1'b0);
      issue(8'h80, 32'h22, 32'd0, 1'b0, 1'b0);
      chk("mt_hi", ifc.hi, 32'h11);
      chk("mt_lo", ifc.lo, 32'h22);

      // flush during cycle 10 of a divide
      issue(8'h04, 32'd100, 32'd3, 1'b0, 1'b0);
      repeat (9) @(negedge clk);
      ifc.flush = 1'b1;
      @(negedge clk);
      ifc.flush = 1'b0;
      chk("fl_busy",  {31'd0, ifc.busy},      32'd0);
      chk("fl_ready", {31'd0, ifc.req_ready}, 32'd1);
      chk("fl_done",  {31'd0, ifc.done},      32'd0);
      chk("fl_hi",    ifc.hi, 32'h11);
      chk("fl_lo",    ifc.lo, 32'h22);
      run_op("fl_divu", 8'h08, 32'd9, 32'd3, 1'b0, 33, 32'd0, 32'd3);

      // exception shadow: done still pulses but HI/LO keep 0 / 3
      run_op("mult_stop", 8'h01, 32'd3, 32'd5, 1'b1, MUL_LAT + 1, 32'd0, 32'd3);

      issue(8'h40, 32'hABCD, 32'd0, 1'b1, 1'b0);
      chk("mthi_stop", ifc.hi, 32'd0);
      issue(8'h40, 32'h1234, 32'd0, 1'b0, 1'b1);
      chk("mthi_flush", ifc.hi, 32'd0);
      issue(8'h40, 32'hABCD, 32'd0, 1'b0, 1'b0);
      chk("mthi", ifc.hi, 32'hABCD);

      ifc.req_op = 8'h10;
      #1 chk("mfhi_rd", ifc.rd_data, 32'hABCD);
      ifc.req_op = 8'h20;
      #1 chk("mflo_rd", ifc.rd_data, 32'd3);
      ifc.req_op = 8'h01;
      #1 chk("rd_other", ifc.rd_data, 32'd0);
      ifc.req_op = 8'h00;

      // asynchronous reset mid-cycle in cycle 20 of a divide
      issue(8'h04, 32'd1000, 32'd7, 1'b0, 1'b0);
      repeat (19) @(negedge clk);
      #2 reset = 1'b1;
      #1;
      chk("arst_busy",  {31'd0, ifc.busy},      32'd0);
      chk("arst_ready", {31'd0, ifc.req_ready}, 32'd1);
      chk("arst_hi",    ifc.hi, 32'd0);
      chk("arst_lo",    ifc.lo, 32'd0);
      @(negedge clk);
      reset = 1'b0;
      count_done(40, n_done);
      chk("arst_no_done", 32'(n_done), 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
